pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline. Tracks per-stage valid bits and detects RAW hazards (no forwarding).
//  Stalls IF/ID on hazards, flushes wrong-path instructions on taken jumps, and drains/halts the pipeline on request.
//  Sits beside the CPU datapath. The CPU gates PC update with pc_en and IF/ID capture with if_id_en.
//  The CPU qualifies mem_wen with mem_valid and rf_wen with wb_valid.
// PARAMETERS
//  RF_BYPASS  0   1: reg file returns same-cycle write data on read, so WB-stage hazards are ignored
//  CNT_W      16  width of saturating stall/flush counters
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      synchronous, active-high
//  id_rs1_addr   in   5      rs1 of instruction in ID
//  id_rs1_used   in   1      ID instruction reads rs1
//  id_rs2_addr   in   5      rs2 of instruction in ID
//  id_rs2_used   in   1      ID instruction reads rs2
//  ex_rd_addr    in   5      id_ex rd;  ex_rf_wen  in 1  id_ex rf_wen
//  mem_rd_addr   in   5      ex_mem rd; mem_rf_wen in 1  ex_mem rf_wen
//  wb_rd_addr    in   5      mem_wb rd; wb_rf_wen  in 1  mem_wb rf_wen
//  jump_flag     in   1      jump taken by instruction in EX
//  halt_req      in   1      level: drain and hold pipeline while high
//  pc_en         out  1      PC may update (next seq or jump target)
//  if_id_en      out  1      IF/ID register captures
//  id_valid, ex_valid, mem_valid, wb_valid  out 1 each   stage holds a live instruction
//  halted        out  1      pipeline empty and frozen
//  stall_cnt     out  CNT_W  hazard-stall cycles, saturating
//  flush_cnt     out  CNT_W  taken-jump flushes, saturating
// BEHAVIOUR
//  Reset: all valids=0, state=RUN, halted=0, counters=0. While reset is high: pc_en=0, if_id_en=0.
//  haz(r) = r!=0 & ((ex_valid&ex_rf_wen&ex_rd_addr==r) | (mem_valid&mem_rf_wen&mem_rd_addr==r)
//           | (!RF_BYPASS&wb_valid&wb_rf_wen&wb_rd_addr==r)).
//  stall = id_valid & ((id_rs1_used&haz(rs1)) | (id_rs2_used&haz(rs2))).  x0 never hazards.
//  flush = ex_valid & jump_flag. Flush beats stall.
//  Every cycle: wb_valid<=mem_valid; mem_valid<=ex_valid.
//  flush: pc_en=1 (loads target), if_id_en=1; id_valid<=0, ex_valid<=0. Penalty is 2 slots; flush_cnt++.
//  stall (no flush): pc_en=0, if_id_en=0; id_valid holds; ex_valid<=0 (bubble); stall_cnt++.
//  Otherwise in RUN: pc_en=1, if_id_en=1, ex_valid<=id_valid, id_valid<=1.
//  FSM RUN -> DRAIN when halt_req=1. DRAIN: no new fetch; pc_en=flush, if_id_en=flush, id_valid<=0.
//   In DRAIN the ID instruction still advances to EX when not stalled and not flushed.
//  DRAIN -> HALTED once all four valids are 0. HALTED: halted=1, pc_en=0, if_id_en=0.
//  HALTED -> RUN when halt_req=0; first fetch on the next cycle. halt_req drop in DRAIN -> RUN immediately.
//  Counters saturate at 2^CNT_W-1. Reset mid-operation clears valids/state/counters in one cycle, with no side effects.
//  All outputs except counters/halted are combinational from registered state plus hazard inputs. No X on outputs after reset.
// TESTING
//  Reset release, no hazards: valids fill id,ex,mem,wb on cycles 1-4; pc_en=1 every cycle.
//  addi x5 in EX, ID reads rs1=x5 -> stall 3 cycles (RF_BYPASS=0) or 2 (RF_BYPASS=1); stall_cnt=3/2; ex_valid bubble each cycle.
//  ID reads x0 while EX writes x0 -> no stall.
//  jump_flag=1 with ex_valid=1 -> id_valid,ex_valid =0 next cycle; pc_en=1; flush_cnt=1.
//  Same cycle stall and flush -> flush wins; stall_cnt unchanged.
//  halt_req=1 with 4 live stages -> halted=1 after 4 cycles; pc_en=0 throughout.
//  halt_req=0 -> id_valid=1 one cycle later. CNT_W=2, 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline sequencer for a 5-stage IF/ID/EX/MEM/WB integer core
//            without forwarding. It keeps one valid bit per stage, detects
//            read-after-write hazards on the ID operands, stalls IF/ID while
//            a hazard is open, squashes wrong-path work on a taken jump, and
//            drains then freezes the pipeline while a halt is requested.
//
// Ports    : clk, reset               clock (rising edge), sync active-high reset
//            id_rs1_addr/id_rs1_used  first source operand of the ID instruction
//            id_rs2_addr/id_rs2_used  second source operand of the ID instruction
//            ex_rd_addr/ex_rf_wen     destination of the instruction in EX
//            mem_rd_addr/mem_rf_wen   destination of the instruction in MEM
//            wb_rd_addr/wb_rf_wen     destination of the instruction in WB
//            jump_flag                EX instruction takes a jump
//            halt_req                 level request to drain and hold
//            pc_en                    PC may advance (sequential or jump target)
//            if_id_en                 IF/ID register captures
//            id/ex/mem/wb_valid       stage holds a live instruction
//            halted                   pipeline empty and frozen
//            stall_cnt, flush_cnt     saturating event counters (CNT_W bits)
//
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int unsigned RF_BYPASS = 0,   // 1: register file forwards same-cycle writes
    parameter int unsigned CNT_W     = 16   // width of the saturating counters
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs1_used,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_rf_wen,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_rf_wen,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_rf_wen,
    input  logic             jump_flag,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             r_id_valid;
    logic             r_ex_valid;
    logic             r_mem_valid;
    logic             r_wb_valid;

    logic             w_id_valid_nxt;
    logic             w_ex_valid_nxt;
    logic             w_mem_valid_nxt;
    logic             w_wb_valid_nxt;
    logic             w_pipe_empty_nxt;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_ex_wr;
    logic             w_mem_wr;
    logic             w_ex_hit_rs1;
    logic             w_ex_hit_rs2;
    logic             w_mem_hit_rs1;
    logic             w_mem_hit_rs2;
    logic             w_wb_hit_rs1;
    logic             w_wb_hit_rs2;
    logic             w_haz_rs1;
    logic             w_haz_rs2;

    logic             w_stall;
    logic             w_flush;
    logic             w_fetch;

    // ------------------------------------------------------------------------
    // RAW hazard detection
    // A downstream stage blocks an operand only when it holds a live
    // instruction that writes the register the operand reads.
    // ------------------------------------------------------------------------
    assign w_ex_wr       = r_ex_valid  & ex_rf_wen;
    assign w_mem_wr      = r_mem_valid & mem_rf_wen;

    assign w_ex_hit_rs1  = w_ex_wr  & (ex_rd_addr  == id_rs1_addr);
    assign w_ex_hit_rs2  = w_ex_wr  & (ex_rd_addr  == id_rs2_addr);
    assign w_mem_hit_rs1 = w_mem_wr & (mem_rd_addr == id_rs1_addr);
    assign w_mem_hit_rs2 = w_mem_wr & (mem_rd_addr == id_rs2_addr);

    // With a write-through register file the WB result is visible to the
    // same-cycle ID read, so WB never needs to hold ID back.
    generate
        if (RF_BYPASS != 0) begin : g_wb_bypass
            assign w_wb_hit_rs1 = 1'b0;
            assign w_wb_hit_rs2 = 1'b0;
        end else begin : g_wb_check
            logic w_wb_wr;
            assign w_wb_wr      = r_wb_valid & wb_rf_wen;
            assign w_wb_hit_rs1 = w_wb_wr & (wb_rd_addr == id_rs1_addr);
            assign w_wb_hit_rs2 = w_wb_wr & (wb_rd_addr == id_rs2_addr);
        end
    endgenerate

    // x0 is hard-wired to zero, so writes to it never create a dependency.
    assign w_haz_rs1 = (|id_rs1_addr) & (w_ex_hit_rs1 | w_mem_hit_rs1 | w_wb_hit_rs1);
    assign w_haz_rs2 = (|id_rs2_addr) & (w_ex_hit_rs2 | w_mem_hit_rs2 | w_wb_hit_rs2);

    assign w_stall = r_id_valid & ((id_rs1_used & w_haz_rs1) | (id_rs2_used & w_haz_rs2));

    // A taken jump squashes IF and ID; it takes precedence over any stall
    // because the stalled ID instruction is on the wrong path anyway.
    assign w_flush = r_ex_valid & jump_flag;

    // New instructions enter only while running with no halt pending. A halt
    // request stops fetch in the same cycle it is raised, and dropping it
    // while draining resumes fetch in the same cycle as well.
    assign w_fetch = (r_state != c_ST_HALTED) & ~halt_req;

    // ------------------------------------------------------------------------
    // Stage valid pipeline
    // ------------------------------------------------------------------------
    always_comb begin
        w_id_valid_nxt = r_id_valid;
        w_ex_valid_nxt = r_id_valid;
        if (w_flush) begin
            w_id_valid_nxt = 1'b0;
            w_ex_valid_nxt = 1'b0;
        end else if (w_stall) begin
            // ID holds its instruction, a bubble goes down to EX
            w_id_valid_nxt = r_id_valid;
            w_ex_valid_nxt = 1'b0;
        end else begin
            w_id_valid_nxt = w_fetch;
            w_ex_valid_nxt = r_id_valid;
        end
    end

    assign w_mem_valid_nxt  = r_ex_valid;
    assign w_wb_valid_nxt   = r_mem_valid;
    assign w_pipe_empty_nxt = ~(w_id_valid_nxt | w_ex_valid_nxt |
                                w_mem_valid_nxt | w_wb_valid_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_id_valid  <= w_id_valid_nxt;
            r_ex_valid  <= w_ex_valid_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_wb_valid  <= w_wb_valid_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Run / drain / halt state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entry to HALTED looks at the valids being loaded this cycle, so the
    // halted flag rises on the first cycle the pipeline is actually empty.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (!halt_req) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_pipe_empty_nxt) begin
                    w_state_nxt = c_ST_HALTED;
                end
            end
            c_ST_HALTED: begin
                if (!halt_req) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    // Outputs. A flush always reloads the PC with the jump target, even while
    // draining, so a later resume continues on the correct path.
    always_comb begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        halted   = (r_state == c_ST_HALTED);
        if (!reset) begin
            if (w_flush) begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end else if (!w_stall && w_fetch) begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_flush) begin
                if (r_flush_cnt != c_CNT_MAX) begin
                    r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
                end
            end else if (w_stall) begin
                if (r_stall_cnt != c_CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign id_valid  = r_id_valid;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Three instances share
//            one stimulus stream: default (no bypass, 16-bit counters),
//            RF_BYPASS=1, and CNT_W=2. A behavioural model per instance
//            feeds a scoreboard every cycle; each scenario task adds its own
//            directed checks on top.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        id_v;
        logic        ex_v;
        logic        mem_v;
        logic        wb_v;
        logic        halted;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } obs_t;

    typedef struct {
        int   st;      // 0 run, 1 drain, 2 halted
        logic id;
        logic ex;
        logic mem;
        logic wb;
        int   scnt;
        int   fcnt;
    } mdl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_rf_wen, mem_rf_wen, wb_rf_wen;
    logic       jump_flag, halt_req;

    logic        d_pc_en [3];
    logic        d_if_id_en [3];
    logic        d_id [3];
    logic        d_ex [3];
    logic        d_mem [3];
    logic        d_wb [3];
    logic        d_halted [3];
    logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
    logic [1:0]  scnt2, fcnt2;

    obs_t act [3];
    obs_t smp [3];
    obs_t sb [$];
    mdl_t m [3];
    int   byp [3]  = '{0, 1, 0};
    int   cmax [3] = '{65535, 65535, 3};

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RF_BYPASS(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_rf_wen(ex_rf_wen),
        .mem_rd_addr(mem_rd_addr), .mem_rf_wen(mem_rf_wen),
        .wb_rd_addr(wb_rd_addr), .wb_rf_wen(wb_rf_wen),
        .jump_flag(jump_flag), .halt_req(halt_req),
        .pc_en(d_pc_en[0]), .if_id_en(d_if_id_en[0]),
        .id_valid(d_id[0]), .ex_valid(d_ex[0]), .mem_valid(d_mem[0]), .wb_valid(d_wb[0]),
        .halted(d_halted[0]), .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    pipe_hazard_ctrl #(.RF_BYPASS(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_rf_wen(ex_rf_wen),
        .mem_rd_addr(mem_rd_addr), .mem_rf_wen(mem_rf_wen),
        .wb_rd_addr(wb_rd_addr), .wb_rf_wen(wb_rf_wen),
        .jump_flag(jump_flag), .halt_req(halt_req),
        .pc_en(d_pc_en[1]), .if_id_en(d_if_id_en[1]),
        .id_valid(d_id[1]), .ex_valid(d_ex[1]), .mem_valid(d_mem[1]), .wb_valid(d_wb[1]),
        .halted(d_halted[1]), .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    pipe_hazard_ctrl #(.RF_BYPASS(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_rf_wen(ex_rf_wen),
        .mem_rd_addr(mem_rd_addr), .mem_rf_wen(mem_rf_wen),
        .wb_rd_addr(wb_rd_addr), .wb_rf_wen(wb_rf_wen),
        .jump_flag(jump_flag), .halt_req(halt_req),
        .pc_en(d_pc_en[2]), .if_id_en(d_if_id_en[2]),
        .id_valid(d_id[2]), .ex_valid(d_ex[2]), .mem_valid(d_mem[2]), .wb_valid(d_wb[2]),
        .halted(d_halted[2]), .stall_cnt(scnt2), .flush_cnt(fcnt2)
    );

    assign act[0] = {d_pc_en[0], d_if_id_en[0], d_id[0], d_ex[0], d_mem[0], d_wb[0],
                     d_halted[0], scnt0, fcnt0};
    assign act[1] = {d_pc_en[1], d_if_id_en[1], d_id[1], d_ex[1], d_mem[1], d_wb[1],
                     d_halted[1], scnt1, fcnt1};
    assign act[2] = {d_pc_en[2], d_if_id_en[2], d_id[2], d_ex[2], d_mem[2], d_wb[2],
                     d_halted[2], 14'd0, scnt2, 14'd0, fcnt2};

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic logic m_haz(input int i, input logic [4:0] r);
        logic hit;
        hit = (m[i].ex  && ex_rf_wen  && (ex_rd_addr  == r)) ||
              (m[i].mem && mem_rf_wen && (mem_rd_addr == r)) ||
              ((byp[i] == 0) && m[i].wb && wb_rf_wen && (wb_rd_addr == r));
        return (r != 5'd0) && hit;
    endfunction

    function automatic void model_eval(input int i, output obs_t e, output mdl_t n);
        mdl_t c;
        logic st, fl, fetch, empty;
        c     = m[i];
        st    = c.id && ((id_rs1_used && m_haz(i, id_rs1_addr)) ||
                         (id_rs2_used && m_haz(i, id_rs2_addr)));
        fl    = c.ex && jump_flag;
        fetch = (c.st != 2) && !halt_req;
        e.pc_en     = !reset && (fl || (!st && fetch));
        e.if_id_en  = e.pc_en;
        e.id_v      = c.id;
        e.ex_v      = c.ex;
        e.mem_v     = c.mem;
        e.wb_v      = c.wb;
        e.halted    = (c.st == 2);
        e.stall_cnt = 16'(c.scnt);
        e.flush_cnt = 16'(c.fcnt);
        n     = c;
        n.wb  = c.mem;
        n.mem = c.ex;
        if (fl) begin
            n.id = 1'b0;
            n.ex = 1'b0;
            if (c.fcnt < cmax[i]) n.fcnt = c.fcnt + 1;
        end else if (st) begin
            n.ex = 1'b0;
            if (c.scnt < cmax[i]) n.scnt = c.scnt + 1;
        end else begin
            n.ex = c.id;
            n.id = fetch;
        end
        empty = !(n.id || n.ex || n.mem || n.wb);
        case (c.st)
            0: if (halt_req) n.st = 1;
            1: if (!halt_req) n.st = 0; else if (empty) n.st = 2;
            2: if (!halt_req) n.st = 0;
            default: n.st = 0;
        endcase
        if (reset) begin
            n.st = 0; n.id = 1'b0; n.ex = 1'b0; n.mem = 1'b0; n.wb = 1'b0;
            n.scnt = 0; n.fcnt = 0;
        end
    endfunction

    // One clock cycle: called at the falling edge with inputs already driven.
    task automatic step();
        obs_t e;
        mdl_t nx [3];
        #1;
        for (int i = 0; i < 3; i++) begin
            model_eval(i, e, nx[i]);
            sb.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            e      = sb.pop_front();
            smp[i] = act[i];
            total++;
            if (act[i] !== e) begin
                $display("FAIL cycle cyc=%0d dut%0d: got pc=%b ifid=%b v=%b%b%b%b h=%b s=%0d f=%0d, want pc=%b ifid=%b v=%b%b%b%b h=%b s=%0d f=%0d",
                         cyc, i, act[i].pc_en, act[i].if_id_en, act[i].id_v, act[i].ex_v,
                         act[i].mem_v, act[i].wb_v, act[i].halted, act[i].stall_cnt, act[i].flush_cnt,
                         e.pc_en, e.if_id_en, e.id_v, e.ex_v, e.mem_v, e.wb_v, e.halted,
                         e.stall_cnt, e.flush_cnt);
            end else begin
                passed++;
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = nx[i];
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_wr(input logic [4:0] exr, input logic exw, input logic [4:0] mr,
                          input logic mw, input logic [4:0] wr, input logic ww);
        ex_rd_addr = exr;  ex_rf_wen  = exw;
        mem_rd_addr = mr;  mem_rf_wen = mw;
        wb_rd_addr = wr;   wb_rf_wen  = ww;
    endtask

    task automatic idle_inputs();
        set_wr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        id_rs1_addr = 5'd0; id_rs1_used = 1'b0;
        id_rs2_addr = 5'd0; id_rs2_used = 1'b0;
        jump_flag = 1'b0;   halt_req = 1'b0;
    endtask

    task automatic refill();
        idle_inputs();
        for (int k = 0; k < 4; k++) step();
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        total++;
        if (smp[0].pc_en !== 1'b0 || smp[0].if_id_en !== 1'b0) begin
            $display("FAIL reset_en: got pc=%b ifid=%b want 0 0", smp[0].pc_en, smp[0].if_id_en);
        end else passed++;
        reset = 1'b0;
        step();
        total++;
        if (smp[0].pc_en !== 1'b1) $display("FAIL release_pc_en: got %b want 1", smp[0].pc_en);
        else passed++;
        total++;
        if ({act[0].id_v, act[0].ex_v} !== 2'b10) begin
            $display("FAIL fill_c1: got id/ex=%b%b want 10", act[0].id_v, act[0].ex_v);
        end else passed++;
        for (int k = 0; k < 3; k++) step();
        total++;
        if ({act[0].id_v, act[0].ex_v, act[0].mem_v, act[0].wb_v} !== 4'b1111) begin
            $display("FAIL fill_c4: got %b%b%b%b want 1111", act[0].id_v, act[0].ex_v,
                     act[0].mem_v, act[0].wb_v);
        end else passed++;
    endtask

    task automatic test_raw();
        refill();
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        set_wr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        total++;
        if (smp[0].pc_en !== 1'b0) $display("FAIL raw_pc_en: got %b want 0", smp[0].pc_en);
        else passed++;
        total++;
        if (act[0].ex_v !== 1'b0) $display("FAIL raw_bubble1: got %b want 0", act[0].ex_v);
        else passed++;
        set_wr(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        step();
        total++;
        if (act[0].ex_v !== 1'b0) $display("FAIL raw_bubble2: got %b want 0", act[0].ex_v);
        else passed++;
        set_wr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        step();
        total++;
        if (act[0].ex_v !== 1'b0) $display("FAIL raw_bubble3: got %b want 0", act[0].ex_v);
        else passed++;
        total++;
        if (act[1].ex_v !== 1'b1) $display("FAIL byp_wb_no_stall: got %b want 1", act[1].ex_v);
        else passed++;
        total++;
        if (act[0].stall_cnt !== 16'd3) $display("FAIL raw_stall_cnt: got %0d want 3", act[0].stall_cnt);
        else passed++;
        total++;
        if (act[1].stall_cnt !== 16'd2) $display("FAIL byp_stall_cnt: got %0d want 2", act[1].stall_cnt);
        else passed++;
        total++;
        if (act[2].stall_cnt !== 16'd3) $display("FAIL sat_stall_cnt3: got %0d want 3", act[2].stall_cnt);
        else passed++;
        set_wr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        total++;
        if (smp[0].pc_en !== 1'b1) $display("FAIL raw_release_pc_en: got %b want 1", smp[0].pc_en);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_x0();
        refill();
        set_wr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        step();
        total++;
        if (smp[0].pc_en !== 1'b1) $display("FAIL x0_pc_en: got %b want 1", smp[0].pc_en);
        else passed++;
        total++;
        if (act[0].stall_cnt !== 16'd3) $display("FAIL x0_stall_cnt: got %0d want 3", act[0].stall_cnt);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_flush();
        refill();
        jump_flag = 1'b1;
        step();
        total++;
        if (smp[0].pc_en !== 1'b1 || smp[0].if_id_en !== 1'b1) begin
            $display("FAIL flush_en: got pc=%b ifid=%b want 1 1", smp[0].pc_en, smp[0].if_id_en);
        end else passed++;
        total++;
        if ({act[0].id_v, act[0].ex_v} !== 2'b00) begin
            $display("FAIL flush_squash: got id/ex=%b%b want 00", act[0].id_v, act[0].ex_v);
        end else passed++;
        total++;
        if (act[0].flush_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d want 1", act[0].flush_cnt);
        else passed++;
        // Jump still asserted but EX now holds a bubble: no second flush.
        step();
        total++;
        if (act[0].flush_cnt !== 16'd1 || act[0].id_v !== 1'b1) begin
            $display("FAIL back_to_back_jump: got f=%0d id=%b want 1 1", act[0].flush_cnt, act[0].id_v);
        end else passed++;
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        refill();
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        set_wr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        jump_flag = 1'b1;
        step();
        total++;
        if (smp[0].pc_en !== 1'b1) $display("FAIL sf_pc_en: got %b want 1", smp[0].pc_en);
        else passed++;
        total++;
        if (act[0].stall_cnt !== 16'd3 || act[0].flush_cnt !== 16'd2) begin
            $display("FAIL sf_counts: got s=%0d f=%0d want 3 2", act[0].stall_cnt, act[0].flush_cnt);
        end else passed++;
        idle_inputs();
    endtask

    task automatic test_saturation();
        refill();
        id_rs2_addr = 5'd7; id_rs2_used = 1'b1;
        set_wr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_wr(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        step();
        set_wr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        step();
        idle_inputs();
        step();
        total++;
        if (act[2].stall_cnt !== 16'd3) $display("FAIL sat_hold: got %0d want 3", act[2].stall_cnt);
        else passed++;
        total++;
        if (act[0].stall_cnt !== 16'd6) $display("FAIL stall_cnt6: got %0d want 6", act[0].stall_cnt);
        else passed++;
        total++;
        if (act[1].stall_cnt !== 16'd4) $display("FAIL byp_stall_cnt4: got %0d want 4", act[1].stall_cnt);
        else passed++;
    endtask

    task automatic test_halt();
        refill();
        halt_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (smp[0].pc_en !== 1'b0) $display("FAIL halt_pc_en k=%0d: got %b want 0", k, smp[0].pc_en);
            else passed++;
            if (k == 2) begin
                total++;
                if (act[0].halted !== 1'b0) $display("FAIL halt_early: got %b want 0", act[0].halted);
                else passed++;
            end
        end
        total++;
        if (act[0].halted !== 1'b1 ||
            {act[0].id_v, act[0].ex_v, act[0].mem_v, act[0].wb_v} !== 4'b0000) begin
            $display("FAIL halted: got h=%b v=%b%b%b%b want 1 0000", act[0].halted,
                     act[0].id_v, act[0].ex_v, act[0].mem_v, act[0].wb_v);
        end else passed++;
        step();
        halt_req = 1'b0;
        step();
        total++;
        if (smp[0].pc_en !== 1'b0 || act[0].id_v !== 1'b0) begin
            $display("FAIL resume_c0: got pc=%b id=%b want 0 0", smp[0].pc_en, act[0].id_v);
        end else passed++;
        step();
        total++;
        if (smp[0].pc_en !== 1'b1 || act[0].id_v !== 1'b1) begin
            $display("FAIL resume_c1: got pc=%b id=%b want 1 1", smp[0].pc_en, act[0].id_v);
        end else passed++;
        // Drop the request while still draining: fetch restarts at once.
        refill();
        halt_req = 1'b1;
        step();
        step();
        halt_req = 1'b0;
        step();
        total++;
        if (smp[0].pc_en !== 1'b1 || act[0].id_v !== 1'b1) begin
            $display("FAIL drain_abort: got pc=%b id=%b want 1 1", smp[0].pc_en, act[0].id_v);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        refill();
        reset = 1'b1;
        step();
        total++;
        if (smp[0].pc_en !== 1'b0) $display("FAIL mid_reset_pc_en: got %b want 0", smp[0].pc_en);
        else passed++;
        reset = 1'b0;
        total++;
        if ({act[0].id_v, act[0].ex_v, act[0].mem_v, act[0].wb_v, act[0].halted} !== 5'b00000 ||
            act[0].stall_cnt !== 16'd0 || act[0].flush_cnt !== 16'd0) begin
            $display("FAIL mid_reset_clear: got v=%b%b%b%b h=%b s=%0d f=%0d want all 0",
                     act[0].id_v, act[0].ex_v, act[0].mem_v, act[0].wb_v, act[0].halted,
                     act[0].stall_cnt, act[0].flush_cnt);
        end else passed++;
        step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m[i].st = 0; m[i].id = 1'b0; m[i].ex = 1'b0; m[i].mem = 1'b0; m[i].wb = 1'b0;
            m[i].scnt = 0; m[i].fcnt = 0;
        end
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_raw();
        test_x0();
        test_flush();
        test_stall_flush();
        test_saturation();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
